// File: rtl/burst_mem_reader_pkg.sv
// Shared types and default sizes for the burst memory reader.
// Optional checksum output is enabled with BURST_RD_CHECKSUM_EN.
package burst_mem_reader_pkg;

    localparam int ADDR_W_DEF     = 10;
    localparam int DATA_W_DEF     = 4;
    localparam int LEN_W_DEF      = 11;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Pointer width for a buffer of the given depth (at least one bit).
    function automatic int fifo_ptr_w(input int depth);
        if (depth > 1) begin
            return $clog2(depth);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/burst_mem_reader_if.sv
// Command, RAM read port and output stream of the burst reader.
// The checksum signal exists only when BURST_RD_CHECKSUM_EN is defined.
interface burst_mem_reader_if
    import burst_mem_reader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) ();

    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
`ifdef BURST_RD_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    modport master (
`ifdef BURST_RD_CHECKSUM_EN
        output checksum,
`endif
        input  start,
        input  start_addr,
        input  len,
        output busy,
        output done,
        output rd_addr,
        input  rd_data,
        output out_valid,
        input  out_ready,
        output out_data
    );

    modport slave (
`ifdef BURST_RD_CHECKSUM_EN
        input  checksum,
`endif
        output start,
        output start_addr,
        output len,
        input  busy,
        input  done,
        input  rd_addr,
        output rd_data,
        input  out_valid,
        output out_ready,
        input  out_data
    );

endinterface

// File: rtl/burst_rd_fifo.sv
// Small synchronous output buffer for the burst reader; head is the
// oldest entry, count is the occupancy before the current edge.
module burst_rd_fifo
    import burst_mem_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    output logic [DATA_W-1:0]            head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);

    localparam int PTR_W = fifo_ptr_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return PTR_W'(0);
        end else begin
            return ptr + PTR_W'(1);
        end
    endfunction

    // Qualify requests against the current occupancy.
    always_comb begin
        push_ok_s = push && (count_r != CNT_W'(DEPTH));
        pop_ok_s  = pop && (count_r != CNT_W'(0));
    end

    // Storage; cleared on reset so the head reads zero when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= DATA_W'(0);
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign empty = (count_r == CNT_W'(0));

endmodule

// File: rtl/burst_mem_reader.sv
// Burst read sequencer: walks consecutive RAM addresses, hides the one-cycle
// read latency and streams words with backpressure. BURST_RD_CHECKSUM_EN adds an XOR checksum.
module burst_mem_reader
    import burst_mem_reader_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int LEN_W      = LEN_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input logic                 clk,
    input logic                 rst_n,
    burst_mem_reader_if.master  bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    state_e            state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] last_addr_r;
    logic [LEN_W-1:0]  remaining_r;
    logic              inflight_r;
    logic              busy_r;
    logic              done_r;

    logic              issue_s;
    logic              push_s;
    logic              pop_s;
    logic              drain_done_s;
    logic [CNT_W:0]    occupancy_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic              fifo_empty_s;
    logic [DATA_W-1:0] fifo_head_s;

    burst_rd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (bus.rd_data),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .count     (fifo_count_s),
        .empty     (fifo_empty_s)
    );

    // Credit check: a read is only issued if its word is guaranteed a slot,
    // counting the word already on its way back from the RAM.
    always_comb begin
        occupancy_s = {1'b0, fifo_count_s} + {{CNT_W{1'b0}}, inflight_r};
        push_s      = inflight_r;
        pop_s       = !fifo_empty_s && bus.out_ready;
        if ((state_r == ST_READ) && (remaining_r != LEN_W'(0)) &&
            (occupancy_s < (CNT_W + 1)'(FIFO_DEPTH))) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
        if (!inflight_r && ((fifo_count_s == CNT_W'(0)) ||
                            ((fifo_count_s == CNT_W'(1)) && pop_s))) begin
            drain_done_s = 1'b1;
        end else begin
            drain_done_s = 1'b0;
        end
    end

    // Sequencer state, address walk, busy and done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            addr_r      <= ADDR_W'(0);
            remaining_r <= LEN_W'(0);
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.len == LEN_W'(0)) begin
                            done_r <= 1'b1;
                        end else begin
                            addr_r      <= bus.start_addr;
                            remaining_r <= bus.len;
                            busy_r      <= 1'b1;
                            state_r     <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (issue_s) begin
                        addr_r      <= addr_r + ADDR_W'(1);
                        remaining_r <= remaining_r - LEN_W'(1);
                        if (remaining_r == LEN_W'(1)) begin
                            state_r <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_done_s) begin
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Tag each issue so the RAM output is captured exactly one cycle later;
    // also remember the last issued address so RD_ADDR holds between issues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_r  <= 1'b0;
            last_addr_r <= ADDR_W'(0);
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                last_addr_r <= addr_r;
            end
        end
    end

    assign bus.rd_addr   = issue_s ? addr_r : last_addr_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.out_valid = !fifo_empty_s;
    assign bus.out_data  = fifo_head_s;

`ifdef BURST_RD_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_r;

    // Running XOR of handed-over words, restarted on every accepted START.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_r <= DATA_W'(0);
        end else if ((state_r == ST_IDLE) && bus.start) begin
            checksum_r <= DATA_W'(0);
        end else if (pop_s) begin
            checksum_r <= checksum_r ^ fifo_head_s;
        end
    end

    assign bus.checksum = checksum_r;
`endif

endmodule

// File: tb/tb_burst_mem_reader.sv
// Scoreboard bench for burst_mem_reader against a behavioural 1024x4 RAM
// preloaded with mem[i] = i[3:0].
module tb_burst_mem_reader;
    import burst_mem_reader_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         ready_mode = 0;
    int         words_seen = 0;
    logic [3:0] exp_q[$];
    logic [3:0] mem [1024];
    logic [3:0] mon_prev;
    bit         mon_stall = 1'b0;

    burst_mem_reader_if bus ();

    burst_mem_reader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Downstream ready pattern: 0 = always ready, 1 = toggle, other = stalled.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ~bus.out_ready;
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compare every handshake with the scoreboard and check stall stability.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_stall = 1'b0;
            end else begin
                if (mon_stall) begin
                    check("hold_valid", int'(bus.out_valid), 1);
                    check("hold_data", int'(bus.out_data), int'(mon_prev));
                end
                if (bus.out_valid && bus.out_ready) begin
                    check("word_expected", (exp_q.size() > 0) ? 1 : 0, 1);
                    if (exp_q.size() > 0) begin
                        check("word", int'(bus.out_data), int'(exp_q.pop_front()));
                    end
                    words_seen++;
                end
                mon_stall = bus.out_valid && !bus.out_ready;
                mon_prev  = bus.out_data;
            end
        end
    end

    task automatic queue_burst(input int addr, input int len, output logic [3:0] ck);
        int a;
        ck = 4'h0;
        for (int i = 0; i < len; i++) begin
            a = (addr + i) % 1024;
            exp_q.push_back(a[3:0]);
            ck = ck ^ a[3:0];
        end
    endtask

    task automatic pulse_start(input int addr, input int len);
        bus.start      = 1'b1;
        bus.start_addr = 10'(addr);
        bus.len        = 11'(len);
        tick();
        bus.start      = 1'b0;
    endtask

    // Called in the first cycle after the START edge (or later, mid-burst).
    task automatic wait_done(input string tag, input int exp_busy, input logic [3:0] exp_ck,
                             input bit lat, input int addr, input int first);
        int busy_cnt = 0;
        bit seen = 1'b0;
        for (int cyc = 1; cyc <= 6000 && !seen; cyc++) begin
            if (lat) begin
                if (cyc == 1) check({tag, "_rd_addr"}, int'(bus.rd_addr), addr);
                if (cyc <= 2) check({tag, "_early_valid"}, int'(bus.out_valid), 0);
                if (cyc == 3) begin
                    check({tag, "_first_valid"}, int'(bus.out_valid), 1);
                    check({tag, "_first_data"}, int'(bus.out_data), first);
                end
            end
            if (bus.done) begin
                seen = 1'b1;
`ifdef BURST_RD_CHECKSUM_EN
                check({tag, "_checksum"}, int'(bus.checksum), int'(exp_ck));
`endif
            end else begin
                if (bus.busy) busy_cnt++;
                tick();
            end
        end
        check({tag, "_done_seen"}, int'(seen), 1);
        if (!seen) return;
        if (exp_busy >= 0) check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
        check({tag, "_busy_at_done"}, int'(bus.busy), 0);
        check({tag, "_valid_at_done"}, int'(bus.out_valid), 0);
        check({tag, "_all_words"}, exp_q.size(), 0);
        tick();
        check({tag, "_done_single"}, int'(bus.done), 0);
    endtask

    task automatic run_burst(input string tag, input int addr, input int len,
                             input int exp_busy, input bit lat);
        logic [3:0] ck;
        int a;
        a = addr % 1024;
        queue_burst(addr, len, ck);
        pulse_start(addr, len);
        wait_done(tag, exp_busy, ck, lat, addr, int'(a[3:0]));
    endtask

    initial begin
        logic [3:0] ck;
        logic [9:0] addr_hold;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 4'(i);
        end
        bus.start      = 1'b0;
        bus.start_addr = 10'd0;
        bus.len        = 11'd0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_valid", int'(bus.out_valid), 0);
        check("rst_data", int'(bus.out_data), 0);
        check("rst_rd_addr", int'(bus.rd_addr), 0);
        rst_n = 1'b1;
        tick();

        run_burst("basic", 5, 4, 6, 1'b1);
        run_burst("wrap", 1022, 4, 6, 1'b1);
        run_burst("len0", 9, 0, 0, 1'b0);

        ready_mode = 1;
        tick();
        run_burst("full_toggle", 7, 1024, -1, 1'b0);
        ready_mode = 0;
        repeat (3) tick();

        // Long stall mid-burst, with an ignored START while busy.
        words_seen = 0;
        queue_burst(100, 40, ck);
        pulse_start(100, 40);
        repeat (6) tick();
        ready_mode = 2;
        repeat (20) tick();
        check("stall_valid", int'(bus.out_valid), 1);
        check("stall_rd_addr", int'(bus.rd_addr), 100 + words_seen + 3);
        addr_hold = bus.rd_addr;
        bus.start      = 1'b1;
        bus.start_addr = 10'd500;
        bus.len        = 11'd2;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        check("stall_frozen", int'(bus.rd_addr), int'(addr_hold));
        check("stall_busy", int'(bus.busy), 1);
        ready_mode = 0;
        wait_done("stall", -1, ck, 1'b0, 0, 0);
        repeat (2) tick();

        // Asynchronous reset in the middle of a burst.
        queue_burst(200, 50, ck);
        pulse_start(200, 50);
        repeat (5) tick();
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_busy", int'(bus.busy), 0);
        check("mid_rst_done", int'(bus.done), 0);
        check("mid_rst_valid", int'(bus.out_valid), 0);
        check("mid_rst_data", int'(bus.out_data), 0);
        check("mid_rst_rd_addr", int'(bus.rd_addr), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_valid", int'(bus.out_valid), 0);
        check("post_rst_busy", int'(bus.busy), 0);

        run_burst("short3", 0, 3, 5, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
